dma_wr_channel: RTL and testbench

- Write-side back end of the DMA engine: drains the engine's 32-bit data FIFO into memory over the AXI master write channels (AW/W/B).
- Splits one transfer command into INCR bursts of up to 16 beats and issues each burst only when the FIFO already holds all of its beats, so WVALID never drops mid-burst.
- Sits between the DMA buffer FIFO (upstream) and the AXI interconnect (downstream).
- Reports busy, a done pulse and a sticky write-error flag back to the engine control logic.

---
 rtl/dma_wr_channel.sv | 150 +++++++++++++++
 tb/tb_dma_wr_channel.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wr_channel.sv
// dma_wr_channel: drains the DMA data FIFO into memory as AXI INCR write bursts (AW/W/B).
// Optional macro DMA_WR_4K_SPLIT_EN additionally clips each burst so it never crosses a 4 KB page.
module dma_wr_channel #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int MAX_BURST          = 16,
   parameter int FIFO_CNT_WIDTH     = 8
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          start,
   input  logic [31:0]                   dest_addr,
   input  logic [31:0]                   xfer_len,
   output logic                          busy,
   output logic                          done,
   output logic                          wr_err,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_rdata,
   input  logic                          fifo_is_empty,
   input  logic [FIFO_CNT_WIDTH-1:0]     fifo_count,
   output logic                          fifo_rden,
   output logic [31:0]                   M_AXI_AWADDR,
   output logic [3:0]                    M_AXI_AWLEN,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic                          M_AXI_WLAST,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic                          M_AXI_BVALID,
   input  logic [1:0]                    M_AXI_BRESP,
   output logic                          M_AXI_BREADY,
   output logic [2:0]                    dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // AW/W valid and their payload stay stable from assertion until that edge.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_AW    = 3'd2,
      S_W     = 3'd3,
      S_B     = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [4:0] MAX_B = 5'(MAX_BURST);

   state_t      state, state_nxt;
   logic [31:0] addr;
   logic [29:0] words_left;
   logic [3:0]  awlen_r;
   logic [3:0]  beat_cnt;
   logic        err_r;
   logic [4:0]  blen;
   logic [4:0]  burst_len;
   logic        w_fire;
   logic        fifo_ready;
   logic        unused_low_bits;

   assign unused_low_bits = ^{dest_addr[1:0], xfer_len[1:0]};

`ifdef DMA_WR_4K_SPLIT_EN
   logic [10:0] page_room;
   assign page_room = 11'd1024 - {1'b0, addr[11:2]};
`endif

   // Length of the next burst, derived from the live address and remaining word count.
   always_comb begin
      blen = (words_left >= 30'(MAX_BURST)) ? MAX_B : words_left[4:0];
`ifdef DMA_WR_4K_SPLIT_EN
      if ({6'b0, blen} > page_room) blen = page_room[4:0];
`endif
   end

   assign burst_len  = {1'b0, awlen_r} + 5'd1;
   assign fifo_ready = 32'(fifo_count) >= 32'(blen);

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) state <= S_IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CHECK;
         S_CHECK: begin
            if (words_left == 30'd0) state_nxt = S_FIN;
            else if (fifo_ready)     state_nxt = S_AW;
         end
         S_AW:    if (M_AXI_AWREADY) state_nxt = S_W;
         S_W:     if (w_fire && M_AXI_WLAST) state_nxt = S_B;
         S_B:     if (M_AXI_BVALID) state_nxt = S_CHECK;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // WVALID is qualified by a non-empty FIFO as a guard; CHECK already ensured the data.
   assign M_AXI_WVALID  = (state == S_W) && !fifo_is_empty;
   assign w_fire        = M_AXI_WVALID && M_AXI_WREADY;
   assign fifo_rden     = w_fire;
   assign M_AXI_WLAST   = (state == S_W) && (beat_cnt == awlen_r);
   assign M_AXI_WDATA   = fifo_rdata;
   assign M_AXI_AWVALID = (state == S_AW);
   assign M_AXI_AWADDR  = addr;
   assign M_AXI_AWLEN   = awlen_r;
   assign M_AXI_BREADY  = (state == S_B);
   assign busy          = (state == S_CHECK) || (state == S_AW) || (state == S_W) || (state == S_B);
   assign done          = (state == S_FIN);
   assign wr_err        = err_r;
   assign dbg_state     = state;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         addr       <= 32'd0;
         words_left <= 30'd0;
         awlen_r    <= 4'd0;
         beat_cnt   <= 4'd0;
         err_r      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr       <= {dest_addr[31:2], 2'b00};
                  words_left <= xfer_len[31:2];
                  err_r      <= 1'b0;
               end
            end
            S_CHECK: begin
               if (state_nxt == S_AW) awlen_r <= 4'(blen - 5'd1);
            end
            S_AW: begin
               if (M_AXI_AWREADY) beat_cnt <= 4'd0;
            end
            S_W: begin
               if (w_fire) beat_cnt <= beat_cnt + 4'd1;
            end
            S_B: begin
               if (M_AXI_BVALID) begin
                  if (M_AXI_BRESP != 2'b00) err_r <= 1'b1;
                  addr       <= addr + {25'd0, burst_len, 2'b00};
                  words_left <= words_left - 30'(burst_len);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_wr_channel.sv
// Self-checking bench for dma_wr_channel: FIFO model, random AXI slave readiness,
// and a burst-splitting reference model computed from addresses and lengths.
`timescale 1ns/1ps
module tb_dma_wr_channel;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic [31:0] dest_addr = 32'd0;
   logic [31:0] xfer_len = 32'd0;
   logic        busy, done, wr_err;
   logic [31:0] fifo_rdata = 32'd0;
   logic        fifo_is_empty = 1'b1;
   logic [7:0]  fifo_count = 8'd0;
   logic        fifo_rden;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready = 1'b1;
   logic [31:0] wdata;
   logic        wlast, wvalid;
   logic        wready = 1'b1;
   logic        bvalid = 1'b1;
   logic [1:0]  bresp = 2'b00;
   logic        bready;
   logic [2:0]  dbg_state;

   dma_wr_channel dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .start(start), .dest_addr(dest_addr), .xfer_len(xfer_len),
      .busy(busy), .done(done), .wr_err(wr_err),
      .fifo_rdata(fifo_rdata), .fifo_is_empty(fifo_is_empty), .fifo_count(fifo_count),
      .fifo_rden(fifo_rden),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BVALID(bvalid), .M_AXI_BRESP(bresp), .M_AXI_BREADY(bready),
      .dbg_state(dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard state ----------------
   logic [35:0] exp_aw_q[$];   // {addr, awlen}
   logic [31:0] exp_w_q[$];
   logic [31:0] fifo_q[$];
   logic [35:0] aw_log[$];
   int          pops_seen = 0, pops_done = 0;
   int          n_done = 0, n_rden = 0, b_total = 0;
   int          err_b_abs = -1;
   bit          rand_rdy = 1'b0;
   bit          mon_en = 1'b0;

   // ---------------- slave / FIFO driver ----------------
   always @(posedge clk) begin
      #1;
      while (pops_done < pops_seen) begin
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         pops_done++;
      end
      fifo_count    = 8'(fifo_q.size());
      fifo_is_empty = (fifo_q.size() == 0);
      fifo_rdata    = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
      awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bresp   = (b_total == err_b_abs) ? 2'b10 : 2'b00;
   end

   // ---------------- monitor ----------------
   bit outstanding = 1'b0, w_open = 1'b0;
   int beat = 0, cur_len = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding = 1'b0; w_open = 1'b0; beat = 0;
      end else if (mon_en) begin
         if (done) n_done++;
         check("rden_is_wfire", fifo_rden, wvalid & wready);
         if (fifo_rden) begin pops_seen++; n_rden++; end
         if (w_open && beat > 0) check("wvalid_hold", wvalid, 1'b1);
         if (awvalid && awready) begin
            check("aw_one_outstanding", outstanding, 1'b0);
            check("aw_expected", exp_aw_q.size() != 0, 1'b1);
            cur_len = awlen;
            if (exp_aw_q.size() != 0) begin
               cur_len = int'(exp_aw_q[0][3:0]);
               check("aw_addr_len", {awaddr, awlen}, exp_aw_q.pop_front());
            end
            aw_log.push_back({awaddr, awlen});
            outstanding = 1'b1; w_open = 1'b1; beat = 0;
         end else if (wvalid) begin
            check("w_after_aw", w_open, 1'b1);
            if (wready) begin
               check("w_expected", exp_w_q.size() != 0, 1'b1);
               if (exp_w_q.size() != 0) check("wdata", wdata, exp_w_q.pop_front());
               check("wlast", wlast, beat == cur_len);
               beat++;
               if (beat > cur_len) w_open = 1'b0;
            end
         end
         if (bvalid && bready) begin
            check("b_after_wlast", w_open, 1'b0);
            outstanding = 1'b0;
            b_total++;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic model_xfer(input logic [31:0] a_in, input logic [31:0] l_in,
                             output int nb, output int nw);
      logic [31:0] a;
      int words, b;
`ifdef DMA_WR_4K_SPLIT_EN
      int room;
`endif
      a = a_in & 32'hFFFF_FFFC;
      words = int'(l_in >> 2);
      nb = 0; nw = words;
      while (words > 0) begin
         b = (words < 16) ? words : 16;
`ifdef DMA_WR_4K_SPLIT_EN
         room = (4096 - int'(a % 4096)) / 4;
         if (room < b) b = room;
`endif
         exp_aw_q.push_back({a, 4'(b - 1)});
         a = a + 32'(b * 4);
         words -= b;
         nb++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_words(input int n);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         fifo_q.push_back(d);
         exp_w_q.push_back(d);
      end
   endtask

   task automatic start_cmd(input logic [31:0] a, input logic [31:0] l);
      @(posedge clk); #1;
      dest_addr = a; xfer_len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_xfer(input int nb, input int nw, input bit exp_err,
                              input int d0, input int r0, input int b0);
      int cyc = 0;
      while (n_done == d0 && cyc < 2000) begin @(negedge clk); cyc++; end
      repeat (2) @(negedge clk);
      check("done_once", n_done - d0, 1);
      check("busy_end", busy, 1'b0);
      check("wr_err_end", wr_err, exp_err);
      check("aw_all_issued", exp_aw_q.size(), 0);
      check("w_all_written", exp_w_q.size(), 0);
      check("rden_count", n_rden - r0, nw);
      check("burst_count", b_total - b0, nb);
   endtask

   task automatic do_xfer(input logic [31:0] a, input logic [31:0] l, input int err_idx, input bit rnd);
      int nb, nw, d0, r0, b0;
      model_xfer(a, l, nb, nw);
      push_words(nw);
      rand_rdy = rnd;
      err_b_abs = (err_idx < 0) ? -1 : b_total + err_idx;
      d0 = n_done; r0 = n_rden; b0 = b_total;
      start_cmd(a, l);
      finish_xfer(nb, nw, (err_idx >= 0) && (err_idx < nb), d0, r0, b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nb, nw, d0, r0, b0, l0, guard;
      bit seen;
      logic [31:0] ra;
      int rw;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_wr_err", wr_err, 1'b0);
      check("rst_rden", fifo_rden, 1'b0);
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_wlast", wlast, 1'b0);
      check("rst_bready", bready, 1'b0);
      check("rst_awaddr", awaddr, 32'd0);
      check("rst_awlen", awlen, 4'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // simple single burst, always-ready slave
      do_xfer(32'h0000_1000, 32'd64, -1, 1'b0);

      // multi-burst, 25 words, random slave readiness
      do_xfer(32'h0000_2000, 32'd100, -1, 1'b1);

      // FIFO holds 5 words until 20 cycles have passed
      model_xfer(32'h0000_3000, 32'd64, nb, nw);
      push_words(5);
      rand_rdy = 1'b1; err_b_abs = -1;
      d0 = n_done; r0 = n_rden; b0 = b_total;
      start_cmd(32'h0000_3000, 32'd64);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_awvalid", awvalid, 1'b0);
      end
      push_words(11);
      finish_xfer(nb, nw, 1'b0, d0, r0, b0);

      // error on first of two bursts, plus an ignored start while busy
      model_xfer(32'h0000_4000, 32'd128, nb, nw);
      push_words(nw);
      rand_rdy = 1'b1; err_b_abs = b_total;
      d0 = n_done; r0 = n_rden; b0 = b_total;
      start_cmd(32'h0000_4000, 32'd128);
      repeat (5) @(negedge clk);
      check("busy_mid", busy, 1'b1);
      start_cmd(32'h0000_9000, 32'd400);
      finish_xfer(nb, nw, 1'b1, d0, r0, b0);

      // next accepted start clears wr_err
      model_xfer(32'h0000_5000, 32'd16, nb, nw);
      push_words(nw);
      err_b_abs = -1;
      d0 = n_done; r0 = n_rden; b0 = b_total;
      start_cmd(32'h0000_5000, 32'd16);
      @(negedge clk);
      check("wr_err_cleared", wr_err, 1'b0);
      finish_xfer(nb, nw, 1'b0, d0, r0, b0);

      // empty transfer: done two cycles after start, no AXI traffic
      d0 = n_done; b0 = b_total;
      @(posedge clk); #1;
      dest_addr = 32'h0000_7000; xfer_len = 32'd3; start = 1'b1;
      @(negedge clk);
      check("empty_c0_done", done, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("empty_c1_done", done, 1'b0);
      check("empty_c1_busy", busy, 1'b1);
      @(negedge clk);
      check("empty_c2_done", done, 1'b1);
      check("empty_c2_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      check("empty_done_once", n_done - d0, 1);
      check("empty_no_burst", b_total - b0, 0);

      // 4 KB page crossing
      l0 = aw_log.size();
      do_xfer(32'h0000_0FF8, 32'd64, -1, 1'b0);
`ifdef DMA_WR_4K_SPLIT_EN
      check("split_bursts", aw_log.size() - l0, 2);
      check("split_first", aw_log[l0], {32'h0000_0FF8, 4'd1});
`else
      check("split_bursts", aw_log.size() - l0, 1);
      check("split_first", aw_log[l0], {32'h0000_0FF8, 4'd15});
`endif

      // random transfers with random error injection
      for (int t = 0; t < 6; t++) begin
         ra = $urandom & 32'hFFFF_FFFC;
         rw = $urandom_range(1, 60);
         do_xfer(ra, 32'(rw * 4 + $urandom_range(0, 3)), $urandom_range(0, 3) - 1, 1'b1);
      end

      // reset asserted during the W phase
      model_xfer(32'h0000_6000, 32'd64, nb, nw);
      push_words(nw);
      rand_rdy = 1'b1; err_b_abs = -1;
      start_cmd(32'h0000_6000, 32'd64);
      seen = 1'b0; guard = 0;
      while (!seen && guard < 200) begin
         @(negedge clk);
         seen = wvalid;
         guard++;
      end
      check("reached_w", seen, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_wr_err", wr_err, 1'b0);
      check("midrst_rden", fifo_rden, 1'b0);
      check("midrst_awvalid", awvalid, 1'b0);
      check("midrst_wvalid", wvalid, 1'b0);
      check("midrst_wlast", wlast, 1'b0);
      check("midrst_bready", bready, 1'b0);
      check("midrst_awaddr", awaddr, 32'd0);
      check("midrst_awlen", awlen, 4'd0);
      repeat (2) @(negedge clk);
      exp_aw_q.delete(); exp_w_q.delete(); fifo_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // channel works again after reset
      do_xfer(32'h0000_8000, 32'd40, 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
